eram_responder: RTL and testbench
=================================

ERAM_RESPONDER -- requirements
Module: eram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning internal storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before grant (0..15).
REQ-003 SHALL have parameter CE_BIT, default 3, meaning bus_ce_i index that selects this responder.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port bus_req_i, input, 1, initiator request, held high until grant.
REQ-007 SHALL have port bus_ce_i, input, 8, one-hot chip enables.
REQ-008 SHALL have port bus_addr_i, input, 32, byte address.
REQ-009 SHALL have port bus_we_i, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port bus_hb_i, input, 2, access size: 00 byte, 01 half-word, 10 word, 11 treated as word.
REQ-011 SHALL have port bus_wdata_i, input, 32, write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port bus_gnt_o, output, 1, one-cycle grant/completion pulse.
REQ-013 SHALL have port eram_data_o, output, 32, full aligned read word, valid only while bus_gnt_o is high.

Function
REQ-014 SHALL be selected when bus_req_i & bus_ce_i[CE_BIT] is high at a rising edge while in IDLE.
REQ-015 SHALL latch addr, we, hb and wdata at acceptance; later input changes during the transaction are ignored.
REQ-016 SHALL implement states IDLE, WAIT, ACK: IDLE->WAIT on selection (IDLE->ACK if WAIT_CYCLES = 0); WAIT->ACK when wait counter reaches WAIT_CYCLES-1; ACK->IDLE unconditionally.
REQ-017 SHALL assert bus_gnt_o only in ACK, exactly one cycle; acceptance at edge N gives grant during cycle N+1+WAIT_CYCLES.
REQ-018 SHALL abort WAIT to IDLE, with no write and no grant, if bus_req_i or bus_ce_i[CE_BIT] drops.
REQ-019 SHALL perform a write at the edge ending ACK, using byte enables: byte -> lane addr[1:0]; half -> lanes {addr[1],0},{addr[1],1}; word -> all four lanes; addr[0] ignored for half, addr[1:0] ignored for word.
REQ-020 SHALL shift write data to the selected lane(s); unselected bytes unchanged.
REQ-021 SHALL drive eram_data_o = stored word at addr[log2(DEPTH_WORDS)+1:2] during ACK of a read, 32'd0 otherwise (including write ACK).
REQ-022 SHALL wrap: address bits above the index range are ignored (alias).
REQ-023 SHALL accept a new request in the cycle after ACK (back-to-back with one IDLE cycle); a request still high in that IDLE cycle is a new transaction.
REQ-024 SHALL not react to bus_req_i when bus_ce_i[CE_BIT] is low, regardless of other ce bits.

Reset
REQ-025 SHALL, on rst_ni low, immediately force state IDLE, wait counter 0, bus_gnt_o 0, eram_data_o 0; latched request cleared.
REQ-026 SHALL, on reset mid-WAIT or mid-ACK, cancel the pending write; storage contents are not cleared by reset.
REQ-027 SHALL release from reset synchronously-safe: first acceptance possible at the first rising edge after rst_ni rises.

Structure
REQ-028 SHALL take HB encodings (byte/half/word), CE index constants and the state enum from shared package bus_pkg.
REQ-029 SHALL use one sub-module, bus_be_decode, mapping (hb, addr[1:0], wdata) to 4-bit byte enable and lane-shifted data.
REQ-030 SHALL implement storage as a synchronous word array with per-byte write enables, inferable as block RAM.

Verification
REQ-031 SHALL cover word write then read: write 0xDEADBEEF to 0x100, read 0x100 -> gnt 3 cycles after acceptance each, eram_data_o = 0xDEADBEEF.
REQ-032 SHALL cover sub-word writes: word 0x00000000 at 0x20, byte 0xAB at 0x22, half 0x1234 at 0x20 -> read 0x20 = 0x00AB1234.
REQ-033 SHALL cover abort: req high 1 cycle into WAIT then low -> no gnt, memory unchanged on later read.
REQ-034 SHALL cover ce mismatch: req high with ce = 8'b0000_0010 -> gnt never asserts, state stays IDLE.
REQ-035 SHALL cover reset mid-WAIT of write 0x55 to 0x40 -> gnt 0, eram_data_o 0 immediately; later read 0x40 returns prior value.
REQ-036 SHALL cover WAIT_CYCLES = 0 and address aliasing: read at 0x40 and 0x40+4*DEPTH_WORDS -> same data, gnt one cycle after acceptance.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus encodings, chip-enable indices and responder state enum
package bus_pkg;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  localparam int CE_ERAM = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } bus_state_e;

endpackage

// File: rtl/bus_be_decode.sv
// rtl/bus_be_decode.sv - access size and low address to byte enables and lane-replicated write data
module bus_be_decode
  import bus_pkg::*;
(
  input  logic [1:0]  hb,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  // Replicating the right-aligned data puts it on every candidate lane; be picks the live ones.
  always_comb begin
    be        = 4'b1111;
    lane_data = wdata;
    case (hb)
      HB_BYTE: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      HB_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eram_responder.sv
// rtl/eram_responder.sv - wait-stated single-port RAM responder on the chip-enable bus
module eram_responder
  import bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int CE_BIT      = CE_ERAM
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bus_req_i,
  input  logic [7:0]  bus_ce_i,
  input  logic [31:0] bus_addr_i,
  input  logic        bus_we_i,
  input  logic [1:0]  bus_hb_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_gnt_o,
  output logic [31:0] eram_data_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  bus_state_e    state_q;
  logic [3:0]    cnt_q;
  logic          gnt_q;
  logic [AW+1:0] addr_q;
  logic          we_q;
  logic [1:0]    hb_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          sel;
  logic [AW-1:0] rd_idx;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic          unused_bits;

  assign sel         = bus_req_i & bus_ce_i[CE_BIT];
  assign unused_bits = ^{bus_addr_i[31:AW+2], bus_ce_i};

  // With zero wait states the read happens on the acceptance edge, before addr_q is loaded.
  assign rd_idx = (state_q == ST_IDLE) ? bus_addr_i[AW+1:2] : addr_q[AW+1:2];

  bus_be_decode u_be_decode (
    .hb        (hb_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .be        (be),
    .lane_data (lane_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      hb_q    <= 2'b00;
      wdata_q <= 32'd0;
    end else begin
      gnt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel) begin
            addr_q  <= bus_addr_i[AW+1:0];
            we_q    <= bus_we_i;
            hb_q    <= bus_hb_i;
            wdata_q <= bus_wdata_i;
            cnt_q   <= 4'd0;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_ACK;
              gnt_q   <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!sel) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == LAST_WAIT) begin
            state_q <= ST_ACK;
            gnt_q   <= 1'b1;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset during ACK clears state_q so the write below never fires.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_ACK && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
    rdata_q <= mem[rd_idx];
  end

  assign bus_gnt_o   = gnt_q;
  assign eram_data_o = (gnt_q && !we_q) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_eram_responder.sv
// tb/tb_eram_responder.sv - directed checks of eram_responder with 2 and 0 wait states
module tb_eram_responder;
  import bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_a, we_a, gnt_a, req_b, we_b, gnt_b;
  logic [7:0]  ce_a, ce_b;
  logic [1:0]  hb_a, hb_b;
  logic [31:0] addr_a, wd_a, data_a, addr_b, wd_b, data_b;

  int          total;
  int          passed;
  int          fails;
  int          lat;
  logic [31:0] rd;
  logic        seen;

  eram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .CE_BIT(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus_req_i(req_a), .bus_ce_i(ce_a),
    .bus_addr_i(addr_a), .bus_we_i(we_a), .bus_hb_i(hb_a), .bus_wdata_i(wd_a),
    .bus_gnt_o(gnt_a), .eram_data_o(data_a)
  );

  eram_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .CE_BIT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus_req_i(req_b), .bus_ce_i(ce_b),
    .bus_addr_i(addr_b), .bus_we_i(we_b), .bus_hb_i(hb_b), .bus_wdata_i(wd_b),
    .bus_gnt_o(gnt_b), .eram_data_o(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic req, input logic [7:0] ce, input logic we,
                       input logic [1:0] hb, input logic [31:0] addr, input logic [31:0] wd);
    if (b) begin
      req_b = req; ce_b = ce; we_b = we; hb_b = hb; addr_b = addr; wd_b = wd;
    end else begin
      req_a = req; ce_a = ce; we_a = we; hb_a = hb; addr_a = addr; wd_a = wd;
    end
  endtask

  // Counts negedges until grant; optionally corrupts the latched fields while waiting.
  task automatic wait_gnt(input bit b, input bit scr, output int l, output logic [31:0] d);
    l = 0;
    d = 32'd0;
    for (int k = 1; k <= 20 && l == 0; k++) begin
      @(negedge clk);
      if ((b ? gnt_b : gnt_a) === 1'b1) begin
        l = k;
        d = b ? data_b : data_a;
      end else if (scr) begin
        if (b) begin
          addr_b = ~addr_b; wd_b = ~wd_b; we_b = ~we_b; hb_b = ~hb_b;
        end else begin
          addr_a = ~addr_a; wd_a = ~wd_a; we_a = ~we_a; hb_a = ~hb_a;
        end
      end
    end
  endtask

  task automatic txn(input bit b, input logic we, input logic [1:0] hb, input logic [31:0] addr,
                     input logic [31:0] wd, output int l, output logic [31:0] d);
    @(negedge clk);
    drive(b, 1'b1, b ? 8'h01 : 8'h08, we, hb, addr, wd);
    wait_gnt(b, 1'b1, l, d);
    drive(b, 1'b0, 8'h00, 1'b0, HB_WORD, 32'd0, 32'd0);
  endtask

  initial begin
    total = 0; passed = 0; fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, HB_WORD, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, HB_WORD, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("reset_gnt_a", {31'd0, gnt_a}, 32'd0);
    check("reset_data_a", data_a, 32'd0);
    check("reset_gnt_b", {31'd0, gnt_b}, 32'd0);
    check("reset_data_b", data_b, 32'd0);
    rst_n = 1'b1;

    txn(1'b0, 1'b1, HB_WORD, 32'h100, 32'hDEADBEEF, lat, rd);
    check("wr100_lat", lat, 3);
    check("wr100_ack_data", rd, 32'd0);
    @(negedge clk);
    check("gnt_one_cycle", {31'd0, gnt_a}, 32'd0);
    txn(1'b0, 1'b0, HB_WORD, 32'h100, 32'h0, lat, rd);
    check("rd100_lat", lat, 3);
    check("rd100_data", rd, 32'hDEADBEEF);

    txn(1'b0, 1'b1, HB_WORD, 32'h20, 32'h00000000, lat, rd);
    txn(1'b0, 1'b1, HB_BYTE, 32'h22, 32'h000000AB, lat, rd);
    txn(1'b0, 1'b1, HB_HALF, 32'h20, 32'h00001234, lat, rd);
    txn(1'b0, 1'b0, HB_WORD, 32'h20, 32'h0, lat, rd);
    check("subword_20", rd, 32'h00AB1234);
    txn(1'b0, 1'b1, HB_BYTE, 32'h23, 32'hFFFFFF5A, lat, rd);
    txn(1'b0, 1'b1, HB_HALF, 32'h21, 32'hFFFF9876, lat, rd);
    txn(1'b0, 1'b0, HB_BYTE, 32'h20, 32'h0, lat, rd);
    check("byte3_half_odd_20", rd, 32'h5AAB9876);
    txn(1'b0, 1'b1, 2'b11, 32'h2F, 32'hCAFEBABE, lat, rd);
    txn(1'b0, 1'b1, HB_HALF, 32'h2E, 32'h0000BEEF, lat, rd);
    txn(1'b0, 1'b0, HB_WORD, 32'h2C, 32'h0, lat, rd);
    check("hb11_word_upper_half_2c", rd, 32'hBEEFBABE);

    txn(1'b0, 1'b1, HB_WORD, 32'h60, 32'h12345678, lat, rd);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h08, 1'b1, HB_WORD, 32'h60, 32'hFFFFFFFF);
    @(negedge clk);
    req_a = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (gnt_a !== 1'b0) seen = 1'b1;
    end
    check("abort_no_gnt", {31'd0, seen}, 32'd0);
    txn(1'b0, 1'b0, HB_WORD, 32'h60, 32'h0, lat, rd);
    check("abort_mem_kept", rd, 32'h12345678);

    @(negedge clk);
    drive(1'b0, 1'b1, 8'b0000_0010, 1'b1, HB_WORD, 32'h100, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) ce_a = 8'hF7;
      @(negedge clk);
      if (gnt_a !== 1'b0) seen = 1'b1;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, HB_WORD, 32'd0, 32'd0);
    check("ce_mismatch_no_gnt", {31'd0, seen}, 32'd0);
    txn(1'b0, 1'b0, HB_WORD, 32'h100, 32'h0, lat, rd);
    check("after_ce_mismatch_lat", lat, 3);
    check("after_ce_mismatch_data", rd, 32'hDEADBEEF);

    txn(1'b0, 1'b1, HB_WORD, 32'h40, 32'hCAFEF00D, lat, rd);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h08, 1'b1, HB_BYTE, 32'h40, 32'h00000055);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wait_gnt", {31'd0, gnt_a}, 32'd0);
    check("rst_wait_data", data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h08, 1'b0, HB_WORD, 32'h40, 32'h0);
    wait_gnt(1'b0, 1'b1, lat, rd);
    check("first_after_reset_lat", lat, 3);
    check("rst_wait_mem_kept", rd, 32'hCAFEF00D);
    rst_n = 1'b0;
    req_a = 1'b0;
    #1;
    check("rst_ack_gnt", {31'd0, gnt_a}, 32'd0);
    check("rst_ack_data", data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b0, 1'b1, 8'h08, 1'b1, HB_BYTE, 32'h40, 32'h000000FF);
    wait_gnt(1'b0, 1'b1, lat, rd);
    rst_n = 1'b0;
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1'b0, HB_WORD, 32'h40, 32'h0, lat, rd);
    check("rst_ack_write_cancelled", rd, 32'hCAFEF00D);

    @(negedge clk);
    drive(1'b0, 1'b1, 8'h08, 1'b0, HB_WORD, 32'h100, 32'h0);
    wait_gnt(1'b0, 1'b0, lat, rd);
    check("b2b_first_data", rd, 32'hDEADBEEF);
    addr_a = 32'h20;
    wait_gnt(1'b0, 1'b0, lat, rd);
    check("b2b_second_lat", lat, 4);
    check("b2b_second_data", rd, 32'h5AAB9876);
    drive(1'b0, 1'b0, 8'h00, 1'b0, HB_WORD, 32'd0, 32'd0);

    txn(1'b1, 1'b1, HB_WORD, 32'h40, 32'hA5A50F0F, lat, rd);
    check("w0_write_lat", lat, 1);
    txn(1'b1, 1'b0, HB_WORD, 32'h40, 32'h0, lat, rd);
    check("w0_read_lat", lat, 1);
    check("w0_read_40", rd, 32'hA5A50F0F);
    txn(1'b1, 1'b0, HB_WORD, 32'h140, 32'h0, lat, rd);
    check("w0_alias_lat", lat, 1);
    check("w0_alias_140", rd, 32'hA5A50F0F);
    txn(1'b1, 1'b1, HB_WORD, 32'h144, 32'h11223344, lat, rd);
    txn(1'b1, 1'b0, HB_WORD, 32'h44, 32'h0, lat, rd);
    check("w0_alias_write_44", rd, 32'h11223344);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
